// File: rtl/bram_frame_writer.sv
// bram_frame_writer
//   Write side of the BRAM filter frame store. Joins the gray pixel stream
//   and the disp/conf stream into one packed word per pixel and writes it
//   into a ring of line slots in a simple dual-port BRAM. Completed lines
//   are tracked as credits; the reader hands each one back with a release
//   pulse. Both input streams stall while every slot holds an unreleased line.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   disp_conf_in_*        disp/conf stream (valid/ready), low 13 bits stored
//   gray_in_*             gray pixel stream (valid/ready)
//   bram_wr_en/addr/data  registered BRAM write port, 1-cycle latency
//   line_done, frame_done one-cycle pulses with the last write of a line/frame
//   line_release          reader pulse: one line slot freed
//   lines_full            completed, unreleased lines
//   release_err           sticky: release received while no line was held
module bram_frame_writer #(
  parameter int dec_frame_w = 120,
  parameter int dec_frame_h = 240,
  parameter int disp_bits   = 5,
  parameter int conf_bits   = 8,
  parameter int buf_lines   = 8,
  parameter int addr_w      = $clog2(buf_lines * dec_frame_w)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [15:0]                       disp_conf_in_data,
  input  logic                              disp_conf_in_valid,
  output logic                              disp_conf_in_ready,
  input  logic [7:0]                        gray_in_data,
  input  logic                              gray_in_valid,
  output logic                              gray_in_ready,
  output logic                              bram_wr_en,
  output logic [addr_w-1:0]                 bram_wr_addr,
  output logic [8+disp_bits+conf_bits-1:0]  bram_wr_data,
  output logic                              line_done,
  output logic                              frame_done,
  input  logic                              line_release,
  output logic [$clog2(buf_lines+1)-1:0]    lines_full,
  output logic                              release_err
);

  localparam int dc_w   = disp_bits + conf_bits;
  localparam int x_w    = $clog2(dec_frame_w);
  localparam int y_w    = $clog2(dec_frame_h);
  localparam int slot_w = (buf_lines > 1) ? $clog2(buf_lines) : 1;
  localparam int lf_w   = $clog2(buf_lines + 1);

  localparam logic [x_w-1:0]    x_last_c    = x_w'(dec_frame_w - 1);
  localparam logic [y_w-1:0]    y_last_c    = y_w'(dec_frame_h - 1);
  localparam logic [slot_w-1:0] slot_last_c = slot_w'(buf_lines - 1);
  localparam logic [lf_w-1:0]   buf_lines_c = lf_w'(buf_lines);
  localparam logic [addr_w-1:0] frame_w_c   = addr_w'(dec_frame_w);

  logic [x_w-1:0]    x_r, x_next_s;
  logic [y_w-1:0]    y_r, y_next_s;
  logic [slot_w-1:0] slot_r, slot_next_s;
  logic [lf_w-1:0]   lf_next_s;
  logic              err_next_s;
  logic              space_s;
  logic              accept_s;
  logic              line_end_s;
  logic              frame_end_s;
  logic [addr_w-1:0] wr_addr_s;

  // Readies only look at registered occupancy and the partner stream's valid,
  // so there is never a path from a ready back into a valid.
  assign space_s            = (lines_full < buf_lines_c);
  assign gray_in_ready      = space_s & disp_conf_in_valid;
  assign disp_conf_in_ready = space_s & gray_in_valid;
  assign accept_s           = space_s & gray_in_valid & disp_conf_in_valid;
  assign line_end_s         = accept_s & (x_r == x_last_c);
  assign frame_end_s        = line_end_s & (y_r == y_last_c);
  assign wr_addr_s          = addr_w'(slot_r) * frame_w_c + addr_w'(x_r);

  // Next-state for pixel position, slot ring and line credit bookkeeping.
  always_comb begin
    x_next_s    = x_r;
    y_next_s    = y_r;
    slot_next_s = slot_r;
    lf_next_s   = lines_full;
    err_next_s  = release_err;

    if (accept_s) begin
      if (line_end_s) begin
        x_next_s = {x_w{1'b0}};
        if (y_r == y_last_c) begin
          y_next_s = {y_w{1'b0}};
        end else begin
          y_next_s = y_r + y_w'(1);
        end
        // The slot ring runs independently of frame boundaries.
        if (slot_r == slot_last_c) begin
          slot_next_s = {slot_w{1'b0}};
        end else begin
          slot_next_s = slot_r + slot_w'(1);
        end
      end else begin
        x_next_s = x_r + x_w'(1);
      end
    end else begin
      x_next_s = x_r;
    end

    // A completion and a release in the same cycle cancel out.
    case ({line_end_s, line_release})
      2'b10: lf_next_s = lines_full + lf_w'(1);
      2'b01: begin
        if (lines_full == {lf_w{1'b0}}) begin
          err_next_s = 1'b1;
        end else begin
          lf_next_s = lines_full - lf_w'(1);
        end
      end
      default: lf_next_s = lines_full;
    endcase
  end

  // State registers and the registered BRAM write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r          <= {x_w{1'b0}};
      y_r          <= {y_w{1'b0}};
      slot_r       <= {slot_w{1'b0}};
      lines_full   <= {lf_w{1'b0}};
      release_err  <= 1'b0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= {addr_w{1'b0}};
      bram_wr_data <= {(8 + dc_w){1'b0}};
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      x_r         <= x_next_s;
      y_r         <= y_next_s;
      slot_r      <= slot_next_s;
      lines_full  <= lf_next_s;
      release_err <= err_next_s;
      bram_wr_en  <= accept_s;
      line_done   <= line_end_s;
      frame_done  <= frame_end_s;
      // Address and data hold their last values between writes.
      if (accept_s) begin
        bram_wr_addr <= wr_addr_s;
        bram_wr_data <= {disp_conf_in_data[dc_w-1:0], gray_in_data};
      end
    end
  end

endmodule

// File: tb/tb_bram_frame_writer.sv
module tb_bram_frame_writer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int B  = 2;
  localparam int AW = 3;
  localparam int DW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   disp_conf_in_data;
  logic          disp_conf_in_valid;
  logic          disp_conf_in_ready;
  logic [7:0]    gray_in_data;
  logic          gray_in_valid;
  logic          gray_in_ready;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [DW-1:0] bram_wr_data;
  logic          line_done;
  logic          frame_done;
  logic          line_release;
  logic [1:0]    lines_full;
  logic          release_err;

  bram_frame_writer #(
    .dec_frame_w(W), .dec_frame_h(H), .disp_bits(5), .conf_bits(8), .buf_lines(B)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_conf_in_data(disp_conf_in_data), .disp_conf_in_valid(disp_conf_in_valid),
    .disp_conf_in_ready(disp_conf_in_ready),
    .gray_in_data(gray_in_data), .gray_in_valid(gray_in_valid), .gray_in_ready(gray_in_ready),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .line_done(line_done), .frame_done(frame_done),
    .line_release(line_release), .lines_full(lines_full), .release_err(release_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ld;
    logic          fd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // bench-side model of the writer position and credits
  int   m_x, m_y, m_slot, m_lf;
  logic obs_gr, obs_dr;

  // scoreboard monitor: every write must match the next expected word
  always @(negedge clk) begin
    if (!reset) begin
      if (bram_wr_en) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%h", bram_wr_addr, bram_wr_data);
        end else begin
          mon_e = q.pop_front();
          if (bram_wr_addr !== mon_e.addr || bram_wr_data !== mon_e.data ||
              line_done !== mon_e.ld || frame_done !== mon_e.fd) begin
            failures++;
            $display("FAIL write got addr=%0d data=%h ld=%b fd=%b exp addr=%0d data=%h ld=%b fd=%b",
                     bram_wr_addr, bram_wr_data, line_done, frame_done,
                     mon_e.addr, mon_e.data, mon_e.ld, mon_e.fd);
          end
        end
      end else if (line_done || frame_done) begin
        checks++;
        failures++;
        $display("FAIL stray_pulse ld=%b fd=%b without write", line_done, frame_done);
      end
    end
  end

  task automatic drive_cycle(input logic gv, input logic dv, input logic [7:0] g,
                             input logic [15:0] dc, input logic rel);
    exp_t e;
    bit acc, inc;
    gray_in_valid = gv; disp_conf_in_valid = dv;
    gray_in_data = g; disp_conf_in_data = dc; line_release = rel;
    #1;
    obs_gr = gray_in_ready;
    obs_dr = disp_conf_in_ready;
    acc = gv && dv && (m_lf < B);
    inc = acc && (m_x == W - 1);
    if (acc) begin
      e.addr = AW'(m_slot * W + m_x);
      e.data = {dc[12:0], g};
      e.ld   = inc;
      e.fd   = inc && (m_y == H - 1);
      q.push_back(e);
      if (m_x == W - 1) begin
        m_x = 0;
        m_y = (m_y == H - 1) ? 0 : m_y + 1;
        m_slot = (m_slot == B - 1) ? 0 : m_slot + 1;
      end else begin
        m_x++;
      end
    end
    if (inc && !rel) m_lf++;
    else if (rel && !inc && m_lf > 0) m_lf--;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    gray_in_valid = 1'b0; disp_conf_in_valid = 1'b0; line_release = 1'b0;
    gray_in_data = 8'h00; disp_conf_in_data = 16'h0000;
    reset = 1'b1;
    #1;
    checks++;
    if ({bram_wr_en, bram_wr_addr, bram_wr_data, line_done, frame_done, lines_full, release_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs en=%b addr=%0d data=%h ld=%b fd=%b lf=%0d err=%b exp all 0",
               bram_wr_en, bram_wr_addr, bram_wr_data, line_done, frame_done, lines_full, release_err);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_x = 0; m_y = 0; m_slot = 0; m_lf = 0;
    q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    drive_cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    checks++;
    if (bram_wr_en !== 1'b0 || lines_full !== 2'd0 || release_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle en=%b lf=%0d err=%b exp 0 0 0", bram_wr_en, lines_full, release_err);
    end
    gray_in_valid = 1'b1; disp_conf_in_valid = 1'b1;
    #1;
    checks++;
    if (gray_in_ready !== 1'b1 || disp_conf_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_readies got %b%b exp 11", gray_in_ready, disp_conf_in_ready);
    end
    gray_in_valid = 1'b0; disp_conf_in_valid = 1'b0;
    #1;
    checks++;
    if (gray_in_ready !== 1'b0 || disp_conf_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_readies got %b%b exp 00", gray_in_ready, disp_conf_in_ready);
    end
  endtask

  task automatic test_single_write();
    drive_cycle(1'b1, 1'b1, 8'h5A, 16'hFABC, 1'b0);
    checks++;
    if (bram_wr_en !== 1'b1 || bram_wr_addr !== 3'd0 || bram_wr_data !== 21'h1ABC5A) begin
      failures++;
      $display("FAIL single_write got en=%b addr=%0d data=%h exp 1 0 1abc5a",
               bram_wr_en, bram_wr_addr, bram_wr_data);
    end
  endtask

  task automatic test_join_hold();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b0, 8'h33, 16'h0123, 1'b0);
      if (obs_gr !== 1'b0 || obs_dr !== 1'b1 || bram_wr_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL join_hold bad_cycles=%0d exp 0 (gray_ready=0, dc_ready=1, no write)", bad);
    end
    drive_cycle(1'b1, 1'b1, 8'h33, 16'h0123, 1'b0);
    checks++;
    if (bram_wr_en !== 1'b1 || bram_wr_addr !== 3'd1) begin
      failures++;
      $display("FAIL join_release got en=%b addr=%0d exp 1 1", bram_wr_en, bram_wr_addr);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    checks++;
    if (bram_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL join_single got en=%b exp 0", bram_wr_en);
    end
  endtask

  task automatic test_stream_full();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b1, 8'(8'h10 + i), 16'(16'hA000 + 17 * i), 1'b0);
    end
    checks++;
    if (lines_full !== 2'd2) begin
      failures++;
      $display("FAIL full_count got %0d exp 2", lines_full);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 8'h18, 16'hA088, 1'b0);
      checks++;
      if (obs_gr !== 1'b0 || obs_dr !== 1'b0 || bram_wr_en !== 1'b0) begin
        failures++;
        $display("FAIL full_stall got rdy=%b%b en=%b exp 00 0", obs_gr, obs_dr, bram_wr_en);
      end
    end
  endtask

  task automatic test_release();
    drive_cycle(1'b1, 1'b1, 8'h18, 16'hA088, 1'b1);
    checks++;
    if (lines_full !== 2'd1 || bram_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL release_count got lf=%0d en=%b exp 1 0", lines_full, bram_wr_en);
    end
    drive_cycle(1'b1, 1'b1, 8'h18, 16'hA088, 1'b0);
    checks++;
    if (obs_gr !== 1'b1 || obs_dr !== 1'b1 || bram_wr_en !== 1'b1 || bram_wr_addr !== 3'd0) begin
      failures++;
      $display("FAIL release_resume got rdy=%b%b en=%b addr=%0d exp 11 1 0",
               obs_gr, obs_dr, bram_wr_en, bram_wr_addr);
    end
    drive_cycle(1'b1, 1'b1, 8'h19, 16'hA099, 1'b0);
  endtask

  task automatic test_frame_end();
    drive_cycle(1'b1, 1'b1, 8'h1A, 16'h7FFF, 1'b0);
    drive_cycle(1'b1, 1'b1, 8'h1B, 16'h0001, 1'b1);
    checks++;
    if (lines_full !== 2'd1) begin
      failures++;
      $display("FAIL release_and_complete got lf=%0d exp 1", lines_full);
    end
    checks++;
    if (frame_done !== 1'b1 || line_done !== 1'b1 || bram_wr_addr !== 3'd3) begin
      failures++;
      $display("FAIL frame_done got fd=%b ld=%b addr=%0d exp 1 1 3", frame_done, line_done, bram_wr_addr);
    end
  endtask

  task automatic test_release_err_and_reset();
    drive_cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    checks++;
    if (lines_full !== 2'd0 || release_err !== 1'b0) begin
      failures++;
      $display("FAIL release_to_zero got lf=%0d err=%b exp 0 0", lines_full, release_err);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    checks++;
    if (lines_full !== 2'd0 || release_err !== 1'b1) begin
      failures++;
      $display("FAIL release_err_set got lf=%0d err=%b exp 0 1", lines_full, release_err);
    end
    drive_cycle(1'b1, 1'b1, 8'h44, 16'h1444, 1'b0);
    drive_cycle(1'b1, 1'b1, 8'h45, 16'h1445, 1'b0);
    drive_cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    checks++;
    if (release_err !== 1'b1) begin
      failures++;
      $display("FAIL release_err_sticky got %b exp 1", release_err);
    end
    apply_reset();
    checks++;
    if (release_err !== 1'b0) begin
      failures++;
      $display("FAIL release_err_clear got %b exp 0", release_err);
    end
    drive_cycle(1'b1, 1'b1, 8'h77, 16'h0777, 1'b0);
    checks++;
    if (bram_wr_en !== 1'b1 || bram_wr_addr !== 3'd0 || bram_wr_data !== 21'h077777) begin
      failures++;
      $display("FAIL reset_midline got en=%b addr=%0d data=%h exp 1 0 077777",
               bram_wr_en, bram_wr_addr, bram_wr_data);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    gray_in_valid = 1'b0; disp_conf_in_valid = 1'b0; line_release = 1'b0;
    gray_in_data = 8'h00; disp_conf_in_data = 16'h0000;
    @(posedge clk); #1;
    test_reset();
    test_single_write();
    test_join_hold();
    test_stream_full();
    test_release();
    test_frame_end();
    test_release_err_and_reset();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes pending=%0d exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
